// File: rtl/iob_cpu_bus_arbiter_pkg.sv
// Shared definitions for the two-master iob bus arbiter: FSM encoding and master indices.
package iob_cpu_bus_arbiter_pkg;

   localparam logic [1:0] IDLE      = 2'd0;
   localparam logic [1:0] LOCK      = 2'd1;
   localparam logic [1:0] WAIT_RESP = 2'd2;

   localparam logic MASTER_I = 1'b0;
   localparam logic MASTER_D = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE      = IDLE,
      S_LOCK      = LOCK,
      S_WAIT_RESP = WAIT_RESP
   } arb_state_t;

endpackage

// File: rtl/iob_cpu_bus_arbiter_if.sv
// Native iob request/response bundle; the master modport issues requests, the slave modport serves them.
interface iob_cpu_bus_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);

   logic                  valid;
   logic [ADDR_W-1:0]     addr;
   logic [DATA_W-1:0]     wdata;
   logic [DATA_W/8-1:0]   wstrb;
   logic                  ready;
   logic                  rvalid;
   logic [DATA_W-1:0]     rdata;

   modport master (
      output valid, addr, wdata, wstrb,
      input  ready, rvalid, rdata
   );

   modport slave (
      input  valid, addr, wdata, wstrb,
      output ready, rvalid, rdata
   );

endinterface

// File: rtl/iob_cpu_bus_arbiter_grant.sv
// Combinational two-way grant: round-robin against the last winner, or fixed priority to the data bus.
module iob_cpu_bus_arbiter_grant
   import iob_cpu_bus_arbiter_pkg::*;
#(
   parameter int RR = 1
) (
   input  logic valid0,
   input  logic valid1,
   input  logic last,
   output logic grant
);

   always_comb begin
      grant = MASTER_I;
      if (valid0 && valid1) begin
         if (RR != 0) begin
            grant = ~last;
         end else begin
            grant = MASTER_D;
         end
      end else if (valid1) begin
         grant = MASTER_D;
      end
   end

endmodule

// File: rtl/iob_cpu_bus_arbiter.sv
// Merges the CPU instruction (m0) and data (m1) iob buses onto one slave port with one read in flight.
module iob_cpu_bus_arbiter
   import iob_cpu_bus_arbiter_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int RR     = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   iob_cpu_bus_arbiter_if.slave  m0,
   iob_cpu_bus_arbiter_if.slave  m1,
   iob_cpu_bus_arbiter_if.master s,
   output logic                  err
);

   arb_state_t            state, state_nxt;
   logic                  owner, owner_nxt;
   logic                  last, last_nxt;
   logic                  err_nxt;
   logic                  grant;
   logic                  sel;
   logic                  req_valid;
   logic                  is_read;
   logic [ADDR_W-1:0]     addr_sel;
   logic [DATA_W-1:0]     wdata_sel;
   logic [DATA_W/8-1:0]   wstrb_sel;

   iob_cpu_bus_arbiter_grant #(
      .RR(RR)
   ) u_grant (
      .valid0 (m0.valid),
      .valid1 (m1.valid),
      .last   (last),
      .grant  (grant)
   );

   // Once a request has been stalled, the owner keeps the port regardless of priority.
   always_comb begin
      sel       = (state == S_LOCK) ? owner : grant;
      req_valid = (state != S_WAIT_RESP) && (sel ? m1.valid : m0.valid);
      addr_sel  = sel ? m1.addr  : m0.addr;
      wdata_sel = sel ? m1.wdata : m0.wdata;
      wstrb_sel = sel ? m1.wstrb : m0.wstrb;
      is_read   = (wstrb_sel == '0);
   end

   always_comb begin
      s.valid = req_valid;
      s.addr  = req_valid ? addr_sel  : '0;
      s.wdata = req_valid ? wdata_sel : '0;
      s.wstrb = req_valid ? wstrb_sel : '0;

      m0.ready = req_valid && (sel == MASTER_I) && s.ready;
      m1.ready = req_valid && (sel == MASTER_D) && s.ready;

      m0.rvalid = (state == S_WAIT_RESP) && (owner == MASTER_I) && s.rvalid;
      m1.rvalid = (state == S_WAIT_RESP) && (owner == MASTER_D) && s.rvalid;
      m0.rdata  = s.rdata;
      m1.rdata  = s.rdata;
   end

   always_comb begin
      state_nxt = state;
      owner_nxt = owner;
      last_nxt  = last;
      err_nxt   = err | (s.rvalid && (state != S_WAIT_RESP));
      case (state)
         S_IDLE: begin
            if (req_valid) begin
               if (s.ready) begin
                  last_nxt = grant;
                  if (is_read) begin
                     owner_nxt = grant;
                     state_nxt = S_WAIT_RESP;
                  end
               end else begin
                  owner_nxt = grant;
                  state_nxt = S_LOCK;
               end
            end
         end
         S_LOCK: begin
            // An owner withdrawing its request breaks the handshake; release the lock.
            if (!req_valid) begin
               state_nxt = S_IDLE;
            end else if (s.ready) begin
               last_nxt  = owner;
               state_nxt = is_read ? S_WAIT_RESP : S_IDLE;
            end
         end
         S_WAIT_RESP: begin
            if (s.rvalid) begin
               state_nxt = S_IDLE;
            end
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= S_IDLE;
         owner <= MASTER_I;
         last  <= MASTER_D;
         err   <= 1'b0;
      end else begin
         state <= state_nxt;
         owner <= owner_nxt;
         last  <= last_nxt;
         err   <= err_nxt;
      end
   end

endmodule

// File: tb/tb_iob_cpu_bus_arbiter.sv
// Scoreboard bench for iob_cpu_bus_arbiter: one round-robin and one fixed-priority instance.
`timescale 1ns/1ps
module tb_iob_cpu_bus_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int SW = DW / 8;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [DW-1:0] wdata;
      logic [SW-1:0] wstrb;
      logic [1:0]    rdy;     // {m0_ready, m1_ready}
   } xfer_t;

   typedef struct packed {
      logic [1:0]    dst;     // {m0_rvalid, m1_rvalid}
      logic [DW-1:0] data;
   } resp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic err_rr, err_fp;

   always #5 clk = ~clk;

   iob_cpu_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_rr ();
   iob_cpu_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_rr ();
   iob_cpu_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_rr ();
   iob_cpu_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m0_fp ();
   iob_cpu_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) m1_fp ();
   iob_cpu_bus_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) s_fp ();

   iob_cpu_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(1)) u_rr (
      .clk (clk), .rst (rst), .m0 (m0_rr), .m1 (m1_rr), .s (s_rr), .err (err_rr)
   );

   iob_cpu_bus_arbiter #(.ADDR_W(AW), .DATA_W(DW), .RR(0)) u_fp (
      .clk (clk), .rst (rst), .m0 (m0_fp), .m1 (m1_fp), .s (s_fp), .err (err_fp)
   );

   xfer_t exp_xfer_rr[$];
   xfer_t exp_xfer_fp[$];
   resp_t exp_resp_rr[$];
   resp_t exp_resp_fp[$];

   int n_checks = 0;
   int n_fails  = 0;

   logic [255:0] outs_rr;
   assign outs_rr = 256'({s_rr.valid, s_rr.addr, s_rr.wdata, s_rr.wstrb, m0_rr.ready, m1_rr.ready,
                          m0_rr.rvalid, m1_rr.rvalid, m0_rr.rdata, m1_rr.rdata, err_rr});
   logic [255:0] outs_fp;
   assign outs_fp = 256'({s_fp.valid, s_fp.addr, s_fp.wdata, s_fp.wstrb, m0_fp.ready, m1_fp.ready,
                          m0_fp.rvalid, m1_fp.rvalid, m0_fp.rdata, m1_fp.rdata, err_fp});

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic unexpected(input string name);
      n_checks++;
      n_fails++;
      $display("FAIL %s: DUT produced an event with nothing expected", name);
   endtask

   function automatic xfer_t mkx(input logic [AW-1:0] a, input logic [DW-1:0] d,
                                 input logic [SW-1:0] st, input logic [1:0] rdy);
      mkx = '{addr: a, wdata: d, wstrb: st, rdy: rdy};
   endfunction

   function automatic resp_t mkr(input logic [1:0] dst, input logic [DW-1:0] d);
      mkr = '{dst: dst, data: d};
   endfunction

   // which: 0 = rr m0, 1 = rr m1, 2 = fp m0, 3 = fp m1
   task automatic set_m(input int which, input logic v, input logic [AW-1:0] a,
                        input logic [DW-1:0] d, input logic [SW-1:0] st);
      case (which)
         0: begin m0_rr.valid = v; m0_rr.addr = a; m0_rr.wdata = d; m0_rr.wstrb = st; end
         1: begin m1_rr.valid = v; m1_rr.addr = a; m1_rr.wdata = d; m1_rr.wstrb = st; end
         2: begin m0_fp.valid = v; m0_fp.addr = a; m0_fp.wdata = d; m0_fp.wstrb = st; end
         default: begin m1_fp.valid = v; m1_fp.addr = a; m1_fp.wdata = d; m1_fp.wstrb = st; end
      endcase
   endtask

   task automatic set_s(input bit fp, input logic rdy, input logic rv, input logic [DW-1:0] rd);
      if (fp) begin
         s_fp.ready = rdy; s_fp.rvalid = rv; s_fp.rdata = rd;
      end else begin
         s_rr.ready = rdy; s_rr.rvalid = rv; s_rr.rdata = rd;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic at_neg();
      @(negedge clk);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   // Monitors: every slave-side transfer and every master response must match the head of its queue.
   always @(negedge clk) begin
      if (s_rr.valid && s_rr.ready) begin
         if (exp_xfer_rr.size() == 0) unexpected("rr_xfer");
         else check("rr_xfer", 256'({s_rr.addr, s_rr.wdata, s_rr.wstrb, m0_rr.ready, m1_rr.ready}),
                    256'(exp_xfer_rr.pop_front()));
      end
      if (m0_rr.rvalid || m1_rr.rvalid) begin
         if (exp_resp_rr.size() == 0) unexpected("rr_resp");
         else check("rr_resp", 256'({m0_rr.rvalid, m1_rr.rvalid, m0_rr.rdata}),
                    256'(exp_resp_rr.pop_front()));
      end
   end

   always @(negedge clk) begin
      if (s_fp.valid && s_fp.ready) begin
         if (exp_xfer_fp.size() == 0) unexpected("fp_xfer");
         else check("fp_xfer", 256'({s_fp.addr, s_fp.wdata, s_fp.wstrb, m0_fp.ready, m1_fp.ready}),
                    256'(exp_xfer_fp.pop_front()));
      end
      if (m0_fp.rvalid || m1_fp.rvalid) begin
         if (exp_resp_fp.size() == 0) unexpected("fp_resp");
         else check("fp_resp", 256'({m0_fp.rvalid, m1_fp.rvalid, m0_fp.rdata}),
                    256'(exp_resp_fp.pop_front()));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int w = 0; w < 4; w++) set_m(w, 1'b0, '0, '0, '0);
      set_s(1'b0, 1'b0, 1'b0, '0);
      set_s(1'b1, 1'b0, 1'b0, '0);
      rst = 1'b1;
      tick();
      tick();
      at_neg();
      check("reset_outputs_rr", outs_rr, 256'(0));
      check("reset_outputs_fp", outs_fp, 256'(0));
      tick();
      rst = 1'b0;

      // m0 read, immediate accept, response two cycles after the transfer
      set_m(0, 1'b1, 32'h100, '0, 4'h0);
      set_s(1'b0, 1'b1, 1'b0, '0);
      exp_xfer_rr.push_back(mkx(32'h100, 32'h0, 4'h0, 2'b10));
      at_neg();
      check("t1_m0_ready_same_cycle", 256'(m0_rr.ready), 256'(1));
      tick();
      set_m(0, 1'b0, '0, '0, '0);
      set_s(1'b0, 1'b0, 1'b0, '0);
      at_neg();
      check("t1_wait_s_valid", 256'(s_rr.valid), 256'(0));
      tick();
      set_s(1'b0, 1'b0, 1'b1, 32'hDEADBEEF);
      exp_resp_rr.push_back(mkr(2'b10, 32'hDEADBEEF));
      at_neg();
      check("t1_m0_rdata", 256'(m0_rr.rdata), 256'(32'hDEADBEEF));
      check("t1_m1_rvalid", 256'(m1_rr.rvalid), 256'(0));
      tick();
      set_s(1'b0, 1'b0, 1'b0, '0);

      // simultaneous m0 read / m1 write right after reset, round-robin: m0 first
      do_reset();
      set_m(0, 1'b1, 32'h200, '0, 4'h0);
      set_m(1, 1'b1, 32'h80000004, 32'h12345678, 4'hF);
      set_s(1'b0, 1'b1, 1'b0, '0);
      exp_xfer_rr.push_back(mkx(32'h200, 32'h0, 4'h0, 2'b10));
      exp_xfer_rr.push_back(mkx(32'h80000004, 32'h12345678, 4'hF, 2'b01));
      at_neg();
      check("t2rr_m1_ready_blocked", 256'(m1_rr.ready), 256'(0));
      tick();
      set_m(0, 1'b0, '0, '0, '0);
      set_s(1'b0, 1'b1, 1'b1, 32'hCAFE0001);
      exp_resp_rr.push_back(mkr(2'b10, 32'hCAFE0001));
      at_neg();
      check("t2rr_resp_cycle_s_valid", 256'(s_rr.valid), 256'(0));
      tick();
      set_s(1'b0, 1'b1, 1'b0, '0);
      at_neg();
      check("t2rr_s_addr", 256'(s_rr.addr), 256'(32'h80000004));
      check("t2rr_s_wstrb", 256'(s_rr.wstrb), 256'(4'hF));
      tick();
      set_m(1, 1'b0, '0, '0, '0);
      set_s(1'b0, 1'b0, 1'b0, '0);

      // same stimulus, fixed priority: m1 first
      do_reset();
      set_m(2, 1'b1, 32'h200, '0, 4'h0);
      set_m(3, 1'b1, 32'h80000004, 32'h12345678, 4'hF);
      set_s(1'b1, 1'b1, 1'b0, '0);
      exp_xfer_fp.push_back(mkx(32'h80000004, 32'h12345678, 4'hF, 2'b01));
      exp_xfer_fp.push_back(mkx(32'h200, 32'h0, 4'h0, 2'b10));
      at_neg();
      check("t2fp_s_addr_first", 256'(s_fp.addr), 256'(32'h80000004));
      tick();
      set_m(3, 1'b0, '0, '0, '0);
      at_neg();
      check("t2fp_s_addr_second", 256'(s_fp.addr), 256'(32'h200));
      tick();
      set_m(2, 1'b0, '0, '0, '0);
      set_s(1'b1, 1'b0, 1'b1, 32'hBEEF0002);
      exp_resp_fp.push_back(mkr(2'b10, 32'hBEEF0002));
      at_neg();
      tick();
      set_s(1'b1, 1'b0, 1'b0, '0);

      // m0 stalled five cycles while m1 waits; lock keeps m0 on the port
      set_m(0, 1'b1, 32'h300, 32'hA5A5A5A5, 4'h3);
      set_m(1, 1'b1, 32'h400, 32'h00000055, 4'h1);
      set_s(1'b0, 1'b0, 1'b0, '0);
      exp_xfer_rr.push_back(mkx(32'h300, 32'hA5A5A5A5, 4'h3, 2'b10));
      exp_xfer_rr.push_back(mkx(32'h400, 32'h00000055, 4'h1, 2'b01));
      for (int c = 0; c < 5; c++) begin
         at_neg();
         check($sformatf("t3_lock_addr_c%0d", c), 256'(s_rr.addr), 256'(32'h300));
         check($sformatf("t3_lock_m1_ready_c%0d", c), 256'(m1_rr.ready), 256'(0));
         tick();
      end
      set_s(1'b0, 1'b1, 1'b0, '0);
      at_neg();
      check("t3_m0_accepted", 256'(m0_rr.ready), 256'(1));
      tick();
      set_m(0, 1'b0, '0, '0, '0);
      at_neg();
      check("t3_m1_after_lock", 256'(m1_rr.ready), 256'(1));
      tick();
      set_m(1, 1'b0, '0, '0, '0);
      set_s(1'b0, 1'b0, 1'b0, '0);

      // four back-to-back m1 writes
      set_s(1'b0, 1'b1, 1'b0, '0);
      for (int i = 0; i < 4; i++) begin
         set_m(1, 1'b1, 32'h1000 + 32'(4 * i), 32'h11111111 * 32'(i + 1), 4'hF);
         exp_xfer_rr.push_back(mkx(32'h1000 + 32'(4 * i), 32'h11111111 * 32'(i + 1), 4'hF, 2'b01));
         at_neg();
         check($sformatf("t4_write%0d_ready", i), 256'(m1_rr.ready), 256'(1));
         tick();
      end
      set_m(1, 1'b0, '0, '0, '0);
      set_s(1'b0, 1'b0, 1'b0, '0);
      at_neg();
      check("t4_idle_after_writes", 256'(s_rr.valid), 256'(0));
      check("t5_err_before", 256'(err_rr), 256'(0));

      // stray response in IDLE
      tick();
      set_s(1'b0, 1'b0, 1'b1, 32'h77777777);
      at_neg();
      check("t5_no_rvalid", 256'({m0_rr.rvalid, m1_rr.rvalid}), 256'(0));
      tick();
      set_s(1'b0, 1'b0, 1'b0, '0);
      at_neg();
      check("t5_err_set", 256'(err_rr), 256'(1));
      tick();
      tick();
      tick();
      at_neg();
      check("t5_err_sticky", 256'(err_rr), 256'(1));

      // reset while waiting for a read response; the late response is dropped
      tick();
      set_m(0, 1'b1, 32'h600, '0, 4'h0);
      set_s(1'b0, 1'b1, 1'b0, '0);
      exp_xfer_rr.push_back(mkx(32'h600, 32'h0, 4'h0, 2'b10));
      at_neg();
      tick();
      set_m(0, 1'b0, '0, '0, '0);
      set_s(1'b0, 1'b0, 1'b0, '0);
      at_neg();
      check("t6_wait_s_valid", 256'(s_rr.valid), 256'(0));
      tick();
      rst = 1'b1;
      at_neg();
      check("t6_reset_outputs", outs_rr, 256'(0));
      tick();
      rst = 1'b0;
      set_s(1'b0, 1'b0, 1'b1, 32'h66666666);
      at_neg();
      check("t6_late_no_rvalid", 256'({m0_rr.rvalid, m1_rr.rvalid}), 256'(0));
      tick();
      set_s(1'b0, 1'b0, 1'b0, '0);
      at_neg();
      check("t6_err_set", 256'(err_rr), 256'(1));

      tick();
      tick();
      at_neg();
      check("end_rr_xfer_queue_empty", 256'(exp_xfer_rr.size()), 256'(0));
      check("end_rr_resp_queue_empty", 256'(exp_resp_rr.size()), 256'(0));
      check("end_fp_xfer_queue_empty", 256'(exp_xfer_fp.size()), 256'(0));
      check("end_fp_resp_queue_empty", 256'(exp_resp_fp.size()), 256'(0));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule
